// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : Buffered RV32 decode stage. Instructions are decoded as they
//                enter and held in a DEPTH-entry in-order queue that drains
//                to rename over a valid/ready handshake. Flush empties it.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ALU_OP_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [XLEN-1:0]            out_imm,
    output logic [ALU_OP_W-1:0]        out_alu_op,
    output logic                       out_alu_src,
    output logic                       out_uses_rs1,
    output logic                       out_uses_rs2,
    output logic                       out_reg_write,
    output logic                       out_mem_read,
    output logic                       out_mem_write,
    output logic                       out_mem_to_reg,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [ALU_OP_W-1:0] c_ALU_ADD = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] c_ALU_SUB = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] c_ALU_XOR = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] c_ALU_SRA = ALU_OP_W'(3'b011);
    localparam logic [ALU_OP_W-1:0] c_ALU_AND = ALU_OP_W'(3'b100);

    localparam logic [6:0] c_OP_R  = 7'b0110011;
    localparam logic [6:0] c_OP_I  = 7'b0010011;
    localparam logic [6:0] c_OP_LW = 7'b0000011;
    localparam logic [6:0] c_OP_SW = 7'b0100011;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                uses_rs1;
        logic                uses_rs2;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                illegal;
    } entry_t;

    entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    entry_t               w_dec;
    entry_t               w_head;
    logic                 w_push;
    logic                 w_pop;
    logic [6:0]           w_opcode;
    logic [2:0]           w_f3;
    logic [6:0]           w_f7;
    logic                 w_rd_nz;

    assign w_opcode = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign w_f7     = in_inst[31:25];
    assign w_rd_nz  = |in_inst[11:7];

    assign in_ready  = (r_count != c_CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    // Flush discards any push in the same cycle and makes a pop meaningless.
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    // Decode the incoming word; illegal encodings keep only pc/register fields.
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.rs1     = in_inst[19:15];
        w_dec.rs2     = in_inst[24:20];
        w_dec.rd      = in_inst[11:7];
        w_dec.illegal = 1'b1;
        case (w_opcode)
            c_OP_R: begin
                if (w_f3 == 3'b000 && w_f7 == 7'h00) begin
                    w_dec.alu_op  = c_ALU_ADD;
                    w_dec.illegal = 1'b0;
                end else if (w_f3 == 3'b000 && w_f7 == 7'h20) begin
                    w_dec.alu_op  = c_ALU_SUB;
                    w_dec.illegal = 1'b0;
                end else if (w_f3 == 3'b100 && w_f7 == 7'h00) begin
                    w_dec.alu_op  = c_ALU_XOR;
                    w_dec.illegal = 1'b0;
                end else if (w_f3 == 3'b101 && w_f7 == 7'h20) begin
                    w_dec.alu_op  = c_ALU_SRA;
                    w_dec.illegal = 1'b0;
                end
                if (!w_dec.illegal) begin
                    w_dec.uses_rs1  = 1'b1;
                    w_dec.uses_rs2  = 1'b1;
                    w_dec.reg_write = w_rd_nz;
                end
            end
            c_OP_I: begin
                if (w_f3 == 3'b000 || w_f3 == 3'b111) begin
                    w_dec.alu_op    = (w_f3 == 3'b000) ? c_ALU_ADD : c_ALU_AND;
                    w_dec.imm       = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                    w_dec.alu_src   = 1'b1;
                    w_dec.uses_rs1  = 1'b1;
                    w_dec.reg_write = w_rd_nz;
                    w_dec.illegal   = 1'b0;
                end
            end
            c_OP_LW: begin
                if (w_f3 == 3'b010) begin
                    w_dec.alu_op     = c_ALU_ADD;
                    w_dec.imm        = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                    w_dec.alu_src    = 1'b1;
                    w_dec.uses_rs1   = 1'b1;
                    w_dec.reg_write  = w_rd_nz;
                    w_dec.mem_read   = 1'b1;
                    w_dec.mem_to_reg = 1'b1;
                    w_dec.illegal    = 1'b0;
                end
            end
            c_OP_SW: begin
                if (w_f3 == 3'b010) begin
                    w_dec.alu_op    = c_ALU_ADD;
                    w_dec.imm       = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                    w_dec.alu_src   = 1'b1;
                    w_dec.uses_rs1  = 1'b1;
                    w_dec.uses_rs2  = 1'b1;
                    w_dec.mem_write = 1'b1;
                    w_dec.illegal   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view; forced to zero when the queue is empty.
    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    assign out_pc         = w_head.pc;
    assign out_rs1        = w_head.rs1;
    assign out_rs2        = w_head.rs2;
    assign out_rd         = w_head.rd;
    assign out_imm        = w_head.imm;
    assign out_alu_op     = w_head.alu_op;
    assign out_alu_src    = w_head.alu_src;
    assign out_uses_rs1   = w_head.uses_rs1;
    assign out_uses_rs2   = w_head.uses_rs2;
    assign out_reg_write  = w_head.reg_write;
    assign out_mem_read   = w_head.mem_read;
    assign out_mem_write  = w_head.mem_write;
    assign out_mem_to_reg = w_head.mem_to_reg;
    assign out_illegal    = w_head.illegal;
    assign count          = r_count;

endmodule
`default_nettype wire
